// File: rtl/serial_twos_comp_ctrl.sv
// rtl/serial_twos_comp_ctrl.sv - bit-serial two's-complement negation controller
module serial_twos_comp_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  output logic             busy,
  output logic             ser_out,
  output logic             ser_vld,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]    LAST     = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] result;
  logic [CW-1:0]    cnt;
  logic             seen_one;
  logic             out_bit;
  logic [WIDTH-1:0] result_next;

  // Copy bits up to and including the first 1, invert every bit after it.
  assign out_bit     = seen_one ? ~shift_reg[0] : shift_reg[0];
  assign result_next = {out_bit, result[WIDTH-1:1]};

  // The serial bit is only meaningful while shifting; hold it low otherwise.
  assign ser_out = ser_vld & out_bit;

  // Controller: sequences IDLE -> SHIFT (WIDTH cycles) -> DONE and drives registered status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      result    <= '0;
      cnt       <= '0;
      seen_one  <= 1'b0;
      busy      <= 1'b0;
      ser_vld   <= 1'b0;
      done      <= 1'b0;
      dout      <= '0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shift_reg <= din;
            cnt       <= '0;
            seen_one  <= 1'b0;
            busy      <= 1'b1;
            ser_vld   <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          shift_reg <= {1'b0, shift_reg[WIDTH-1:1]};
          seen_one  <= seen_one | shift_reg[0];
          result    <= result_next;
          cnt       <= cnt + CW'(1);
          if (cnt == LAST) begin
            // Publish the finished word so it is visible for the whole DONE cycle.
            dout    <= result_next;
            ovf     <= (result_next == MOST_NEG);
            ser_vld <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          ser_vld <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_twos_comp_ctrl.md
SERIAL_TWOS_COMP_CTRL -- requirements
Module: serial_twos_comp_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, operand and result width in bits (minimum 2).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request a conversion of din; sampled only in IDLE.
REQ-005 din  input  WIDTH  binary operand, captured on the accepted start edge.
REQ-006 busy  output  1  high while a conversion is in progress (SHIFT and DONE states).
REQ-007 ser_out  output  1  current two's-complement result bit, LSB first.
REQ-008 ser_vld  output  1  qualifies ser_out; high exactly in SHIFT cycles.
REQ-009 done  output  1  one-cycle pulse, result valid.
REQ-010 dout  output  WIDTH  parallel two's-complement result; held from done until the next accepted start.
REQ-011 ovf  output  1  high with done when din was the most-negative value (1 followed by WIDTH-1 zeros); held with dout.

Function
REQ-012 FSM states: IDLE, SHIFT, DONE; encoding free, no other reachable states.
REQ-013 IDLE: start=1 at a rising edge -> capture din into a shift register, clear bit counter and seen_one flag, go to SHIFT.
REQ-014 SHIFT, each cycle: b = shift_reg[0]; out bit = seen_one ? ~b : b; seen_one <= seen_one | b; shift_reg shifts right; out bit shifted into the result register MSB-side (result <= {out, result[WIDTH-1:1]}); counter increments.
REQ-015 ser_out is the combinational out bit of the current SHIFT cycle; ser_vld=1 only in SHIFT.
REQ-016 SHIFT lasts exactly WIDTH cycles; on the cycle counter reaches WIDTH-1, next state is DONE.
REQ-017 DONE lasts exactly one cycle: done=1, dout=result, ovf set as in REQ-011; next state IDLE unconditionally.
REQ-018 Latency: start accepted at edge N -> ser_vld high for cycles N+1..N+WIDTH -> done high in cycle N+WIDTH+1.
REQ-019 start while busy (SHIFT or DONE) is ignored; no queuing, no effect on the running conversion or din capture.
REQ-020 din changes after capture do not affect the running conversion.
REQ-021 Back-to-back: start held high -> next conversion accepted on the edge leaving DONE (one IDLE cycle between done and next SHIFT); throughput one result per WIDTH+2 cycles.
REQ-022 Arithmetic: dout = (2^WIDTH - din) mod 2^WIDTH; din=0 -> dout=0, ovf=0; most-negative din -> dout=din, ovf=1.
REQ-023 dout and ovf retain their last values through IDLE; they update only in DONE.
REQ-024 Counter width ceil(log2(WIDTH))+1 bits; no wrap-around reachable.

Reset
REQ-025 rst=1 forces, asynchronously: state IDLE, busy=0, done=0, ser_vld=0, ser_out=0, dout=0, ovf=0, counter=0, seen_one=0, shift register=0.
REQ-026 Reset mid-conversion aborts it; no done pulse follows; first start after rst deasserts begins a fresh conversion.
REQ-027 start asserted while rst=1 is ignored.

Verification
REQ-028 WIDTH=4, din=0101, start one cycle -> ser_out sequence 1,1,0,1 with ser_vld, done at start+5, dout=1011, ovf=0, busy high cycles +1..+5.
REQ-029 din=0000 -> ser_out 0,0,0,0, dout=0000, ovf=0; din=1000 -> dout=1000, ovf=1.
REQ-030 Exhaustive: din swept 0..15, one conversion each -> every dout equals (16-din) mod 16, ovf only for 1000.
REQ-031 start=1 and din=0011 pulsed during SHIFT of din=0110 -> ignored, dout=1010, exactly one done.
REQ-032 rst pulsed in second SHIFT cycle -> all outputs 0 immediately, no done; then din=0001 converts to 1111.
REQ-033 start held high across two conversions (0010 then 0111) -> done pulses exactly 6 cycles apart, dout 1110 then 1001.
